div32_seq: RTL and testbench

DIV32_SEQ -- requirements
Module: div32_seq

---
 rtl/div32_pkg.sv | 23 ++
 rtl/_32bit_sub.sv | 22 ++
 rtl/div32_seq.sv | 186 ++++++++++++++++++
 tb/tb_div32_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div32_pkg.sv
// -----------------------------------------------------------------------------
// div32_pkg -- shared definitions for the sequential divider.
//   state_e     : divider FSM states (IDLE, RUN, DONE)
//   DIV_WIDTH   : default operand/result width
//   CNT_W       : iteration counter width for the default width
//   cnt_width() : counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package div32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/_32bit_sub.sv
// -----------------------------------------------------------------------------
// _32bit_sub -- two's-complement subtractor: {cout, diff} = a + ~b + cin.
// With cin = 1 this is a - b; cout = 1 means no borrow (a >= b, unsigned).
// Ports:
//   a, b  : input  [WIDTH-1:0] operands
//   cin   : input  carry-in (tie to 1 for a plain subtract)
//   diff  : output [WIDTH-1:0] difference
//   cout  : output carry-out (inverted borrow)
// -----------------------------------------------------------------------------
module _32bit_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] diff,
    output logic             cout
);

    assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/div32_seq.sv
// -----------------------------------------------------------------------------
// div32_seq -- multi-cycle restoring divider, one quotient bit per clock.
// Optional signed support is compiled in with `define DIV32_SIGNED_EN.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start               : launch a division (taken only in IDLE)
//   dividend, divisor   : operands, captured on the accepted start
//   signed_op           : two's-complement mode (DIV32_SIGNED_EN only)
//   busy                : high in RUN and DONE
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : captured divisor was zero, held with results
// -----------------------------------------------------------------------------
module div32_seq
    import div32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q, dsr_d;        // captured divisor
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // One restoring step: the widened subtract keeps the borrow visible even
    // though the shifted remainder can reach WIDTH+1 bits.
    logic [WIDTH:0]   sub_a, sub_b, sub_diff;
    logic             sub_cout;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign sub_a = {rem_q, quo_q[WIDTH-1]};
    assign sub_b = {1'b0, dsr_q};

    _32bit_sub #(.WIDTH(WIDTH + 1)) u_sub (
        .a    (sub_a),
        .b    (sub_b),
        .cin  (1'b1),
        .diff (sub_diff),
        .cout (sub_cout)
    );

    assign step_rem = sub_cout ? sub_diff[WIDTH-1:0] : sub_a[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], sub_cout};

    // Operand conditioning on capture and sign fix-up on completion.
    logic [WIDTH-1:0] cap_dividend, cap_divisor;
    logic [WIDTH-1:0] fin_quo, fin_rem, dz_rem;

`ifdef DIV32_SIGNED_EN
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic sa, sb;

    assign sa           = signed_op & dividend[WIDTH-1];
    assign sb           = signed_op & divisor[WIDTH-1];
    assign cap_dividend = sa ? -dividend : dividend;
    assign cap_divisor  = sb ? -divisor  : divisor;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // The most-negative dividend negates to itself and needs no special case.
    assign fin_quo      = neg_quo_q ? -step_quo : step_quo;
    assign fin_rem      = neg_rem_q ? -step_rem : step_rem;
    // Divide-by-zero hands back the original dividend.
    assign dz_rem       = neg_rem_q ? -quo_q : quo_q;
`else
    assign cap_dividend = dividend;
    assign cap_divisor  = divisor;
    assign fin_quo      = step_quo;
    assign fin_rem      = step_rem;
    assign dz_rem       = quo_q;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a hold default first so the
        // case arms below cannot infer latches.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV32_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = CW'(WIDTH);
                    rem_d     = '0;
                    quo_d     = cap_dividend;
                    dsr_d     = cap_divisor;
                    dbz_d     = 1'b0;
`ifdef DIV32_SIGNED_EN
                    neg_quo_d = sa ^ sb;
                    neg_rem_d = sa;
`endif
                end
            end
            RUN: begin
                if (dsr_q == '0) begin
                    // Zero divisor: no iterations, straight to DONE.
                    state_d     = DONE;
                    cnt_d       = '0;
                    quotient_d  = '1;
                    remainder_d = dz_rem;
                    dbz_d       = 1'b1;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - 1'b1;
                    // The last step's result goes straight to the outputs.
                    if (cnt_q == CW'(1)) begin
                        state_d     = DONE;
                        quotient_d  = fin_quo;
                        remainder_d = fin_rem;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        // NOTE: the reset clears the whole datapath, not just the FSM, so
        // outputs read as zero after reset.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV32_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV32_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// -----------------------------------------------------------------------------
// tb_div32_seq -- directed, table-driven bench for div32_seq (WIDTH = 32).
// Build with +define+DIV32_SIGNED_EN to add the signed vectors.
// -----------------------------------------------------------------------------
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend, divisor;
`ifdef DIV32_SIGNED_EN
    logic        signed_op;
`endif
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div32_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV32_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sop;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one division; operand inputs are scrambled right after
    // acceptance so they must not leak into the result.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sop,
                           output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
`ifdef DIV32_SIGNED_EN
        signed_op = sop;
`else
        if (sop) $display("note: signed vector requested in unsigned build");
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_q"},    quotient,      32'd0);
        check({tag, "_r"},    remainder,     32'd0);
        check({tag, "_dz"},   {31'b0, div_by_zero}, 32'd0);
    endtask

    initial begin
        int lat, pulses, first;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef DIV32_SIGNED_EN
        signed_op = 1'b0;
`endif
        // {a, b, signed, quotient, remainder, div_by_zero, latency}
        vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 33});
        vecs.push_back('{32'd5,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd5,          1'b0, 33});
        vecs.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 2});
        vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0, 33});
        vecs.push_back('{32'h8000_0000,  32'h10,         1'b0, 32'h0800_0000,  32'd0,          1'b0, 33});
        vecs.push_back('{32'd1000003,    32'd1000,       1'b0, 32'd1000,       32'd3,          1'b0, 33});
        vecs.push_back('{32'd7,          32'd7,          1'b0, 32'd1,          32'd0,          1'b0, 33});
        vecs.push_back('{32'd6,          32'd7,          1'b0, 32'd0,          32'd6,          1'b0, 33});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0, 33});
`ifdef DIV32_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 33});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 33});
        vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back('{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 2});
`endif

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");

        // Table-driven vectors.
        foreach (vecs[i]) begin
            string t;
            t = $sformatf("v%0d", i);
            run_div(vecs[i].a, vecs[i].b, vecs[i].sop, lat);
            check({t, "_lat"},  lat,                  vecs[i].exp_lat);
            check({t, "_q"},    quotient,             vecs[i].exp_q);
            check({t, "_r"},    remainder,            vecs[i].exp_r);
            check({t, "_dz"},   {31'b0, div_by_zero}, {31'b0, vecs[i].exp_dz});
            check({t, "_busy"}, {31'b0, busy},        32'd1);
            @(negedge clk);
            check({t, "_pulse"}, {31'b0, done}, 32'd0);
            check({t, "_idle"},  {31'b0, busy}, 32'd0);
            repeat (3) @(negedge clk);
            check({t, "_hold_q"}, quotient,  vecs[i].exp_q);
            check({t, "_hold_r"}, remainder, vecs[i].exp_r);
        end

        // Start pulse mid-run is ignored: one done, original result.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
`ifdef DIV32_SIGNED_EN
        signed_op = 1'b0;
`endif
        @(posedge clk); #1 start = 1'b0;
        pulses = 0; first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 10) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        check("ignore_pulses", pulses,    32'd1);
        check("ignore_lat",    first,     32'd33);
        check("ignore_q",      quotient,  32'd14);
        check("ignore_r",      remainder, 32'd2);

        // Reset in the middle of RUN clears everything on the next edge.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (15) @(negedge clk);
        check("midrun_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_zero("midrun_rst");

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("rst_prio_busy2", {31'b0, busy}, 32'd0);

        // Fresh division after reset.
        run_div(32'd9, 32'd3, 1'b0, lat);
        check("post_rst_lat", lat,       32'd33);
        check("post_rst_q",   quotient,  32'd3);
        check("post_rst_r",   remainder, 32'd0);
        @(negedge clk);

        // start held high relaunches on the first IDLE cycle after DONE.
        @(negedge clk);
        dividend = 32'd20; divisor = 32'd4; start = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        check("held_lat1", lat,      32'd33);
        check("held_q1",   quotient, 32'd5);
        @(negedge clk);
        check("held_idle", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("held_relaunch", {31'b0, busy}, 32'd1);
        start = 1'b0; dividend = 32'd21; divisor = 32'd0;
        lat = 1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        check("held_lat2", lat,                  32'd33);
        check("held_q2",   quotient,             32'd5);
        check("held_r2",   remainder,            32'd0);
        check("held_dz2",  {31'b0, div_by_zero}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
